shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 74 +++++++
 tb/tb_shift_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// 32-bit SLL/SRL/SRA/ROR shifter in two stages (coarse 8/16, then fine 1/2/4); 2-cycle latency, 1 op/cycle.
// Valid/ready both sides; a stalled S2 holds both stages and drops in_ready without any path from in_valid.
module shift_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  shamt,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  s;
    logic [1:0]  op;
  } s1_t;

  logic        s1_valid;
  s1_t         s1;
  logic        s2_valid;
  logic        s2_take;
  logic [31:0] s1_next;
  logic [31:0] s2_next;

  // ROR uses d << (32-amt); amt=0 shifts by 32, which yields 0 and leaves d intact.
  function automatic logic [31:0] shift_by(input logic [31:0] d, input logic [4:0] amt,
                                           input logic [1:0] kind);
    logic [31:0] r;
    case (kind)
      2'b00:   r = d << amt;
      2'b01:   r = d >> amt;
      2'b10:   r = $signed(d) >>> amt;
      default: r = (d >> amt) | (d << (6'd32 - {1'b0, amt}));
    endcase
    return r;
  endfunction

  assign s2_take   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_take;
  assign out_valid = s2_valid;
  assign busy      = s1_valid || s2_valid;

  // SRA in S1 keeps bit 31, so S2 can take the sign from S1 data.
  assign s1_next = shift_by(in_data, {shamt[4:3], 3'b000}, op);
  assign s2_next = shift_by(s1.dat, {2'b00, s1.s}, s1.op);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      out_data <= 32'h0000_0000;
    end else begin
      if (s2_take) begin
        s2_valid <= s1_valid;
        if (s1_valid) out_data <= s2_next;
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1.dat <= s1_next;
          s1.s   <= shamt[2:0];
          s1.op  <= op;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomized checks of shift_pipe against a bit-serial reference model and an in-order scoreboard.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int tests = 0;
  int errs  = 0;
  int n_out = 0;
  logic [31:0] expq[$];

  shift_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shamt(shamt), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bit per step, independent of the 8/16 + 1/2/4 split in the design.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] o);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(s)) begin
        case (o)
          2'b00:   r = {r[30:0], 1'b0};
          2'b01:   r = {1'b0, r[31:1]};
          2'b10:   r = {r[31], r[31:1]};
          default: r = {r[0], r[31:1]};
        endcase
      end
    end
    return r;
  endfunction

  // Scoreboard: signals are sampled mid-cycle, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (expq.size() == 0) check("unexpected_out", {31'd0, out_valid}, 32'd0);
        else check("sb_data", out_data, expq.pop_front());
      end
      if (in_valid && in_ready) expq.push_back(ref_shift(in_data, shamt, op));
    end
  end

  task automatic directed(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                          input logic [31:0] exp, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    shamt     = s;
    op        = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_dat"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (expq.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    check(tag, expq.size(), 32'd0);
  endtask

  initial begin
    int n0;
    int sent;
    int cyc;
    logic acc;
    logic [31:0] ea;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; shamt = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'h0000_0000);
    @(posedge clk); #1;
    reset = 1'b0;

    directed(32'h8000_0000, 5'd8,  2'b10, 32'hFF80_0000, "sra8");
    directed(32'h8000_0000, 5'd8,  2'b01, 32'h0080_0000, "srl8");
    directed(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, "sll31");
    directed(32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, "ror8");
    directed(32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, "ror0");
    directed(32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, "sra0");
    directed(32'h8765_4321, 5'd31, 2'b10, 32'hFFFF_FFFF, "sra31");
    directed(32'h8765_4321, 5'd4,  2'b11, 32'h1876_5432, "ror4");
    drain("dir_drain");

    // Full sweep, back-to-back.
    out_ready = 1'b1;
    n0 = n_out;
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 32; s++) begin
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0F0F;
        shamt    = 5'(s);
        op       = 2'(o);
        @(negedge clk);
        check("sweep_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sweep_cnt", n_out - n0, 32'd128);
    drain("sweep_drain");

    // Backpressure: two accepted, third stalled.
    out_ready = 1'b0;
    ea = 32'h1234_5678 << 4;
    in_valid = 1'b1; in_data = 32'h1234_5678; shamt = 5'd4; op = 2'b00;
    @(posedge clk); #1;
    in_data = 32'hF000_000F; shamt = 5'd12; op = 2'b11;
    @(posedge clk); #1;
    in_data = 32'h8000_0001; shamt = 5'd1; op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", out_data, ea);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp_drain");

    // Random valid/ready toggling.
    sent = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (!in_valid || acc) begin
        in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        in_data  = $urandom();
        shamt    = 5'($urandom_range(0, 31));
        op       = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    check("rand_sent", sent, 32'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    // Reset with both stages full plus a coincident input offer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_00FF; shamt = 5'd3; op = 2'b00;
    @(posedge clk); #1;
    in_data = 32'hFFFF_0000; shamt = 5'd5; op = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    check("full_busy", {31'd0, busy}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    in_data = 32'h1111_2222; shamt = 5'd7; op = 2'b11;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_out_data", out_data, 32'h0000_0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst2_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
